// File: rtl/frame_sequencer.sv
// Multi-frame picture store and playback controller for the 5x7 LED path.
// Keeps NFRAMES 35-bit pictures. In STOP the cursor editor may toggle
// pixels of the current frame and step frames by hand; in PLAY a tick
// counter advances the frame index every FRAME_TICKS cycles.
module frame_sequencer #(
  parameter int NFRAMES     = 4,
  parameter int IDX_W       = 2,
  parameter int FRAME_TICKS = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             en,
  input  logic             edit,
  input  logic             place,
  input  logic [34:0]      ens_cursor,
  input  logic             play_toggle,
  input  logic             next_frame,
  output logic [34:0]      frame_out,
  output logic [IDX_W-1:0] frame_idx,
  output logic             playing
);

  localparam int CNT_W = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

  typedef enum logic {
    S_STOP = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [34:0]      frames_reg [NFRAMES];
  logic             wr_en;
  logic [34:0]      wr_data;
  logic [34:0]      frame_out_reg, frame_out_next;
  logic             playing_reg, playing_next;

  // State register: FSM state, tick counter and current frame index.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_reg <= S_STOP;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else if (en) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic: play_toggle beats every other event in either state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wr_en      = 1'b0;
    if (en) begin
      case (state_reg)
        S_STOP: begin
          if (play_toggle) begin
            state_next = S_PLAY;
            cnt_next   = '0;
          end else begin
            // A write lands on the old index even if the index steps now.
            wr_en = edit & place;
            if (next_frame) begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (play_toggle) begin
            state_next = S_STOP;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = idx_reg + IDX_W'(1);
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = S_STOP;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output logic: picture for the upcoming index, including this edge's write.
  always_comb begin
    wr_data      = frames_reg[idx_reg] ^ ens_cursor;
    playing_next = (state_next == S_PLAY);
    if (wr_en && (idx_next == idx_reg)) begin
      frame_out_next = wr_data;
    end else begin
      frame_out_next = frames_reg[idx_next];
    end
  end

  // Frame store: one register per frame, toggled by the editor write.
  generate
    for (genvar gi = 0; gi < NFRAMES; gi++) begin : g_frame
      // Clear on reset; XOR the cursor mask in when this frame is targeted.
      always_ff @(posedge CLOCK_50) begin
        if (rst) begin
          frames_reg[gi] <= '0;
        end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
          frames_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Registered outputs toward the display and status indicator.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      frame_out_reg <= '0;
      playing_reg   <= 1'b0;
    end else if (en) begin
      frame_out_reg <= frame_out_next;
      playing_reg   <= playing_next;
    end
  end

  assign frame_out = frame_out_reg;
  assign frame_idx = idx_reg;
  assign playing   = playing_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed vector table plus randomized run
// checked against a cycle-level behavioural model of the store and player.
module tb_frame_sequencer;

  localparam int NF = 4;
  localparam int IW = 2;
  localparam int FT = 4;

  logic          CLOCK_50 = 1'b0;
  logic          rst, en, edit, place, play_toggle, next_frame;
  logic [34:0]   ens_cursor;
  logic [34:0]   frame_out;
  logic [IW-1:0] frame_idx;
  logic          playing;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  frame_sequencer #(.NFRAMES(NF), .IDX_W(IW), .FRAME_TICKS(FT)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .en         (en),
    .edit       (edit),
    .place      (place),
    .ens_cursor (ens_cursor),
    .play_toggle(play_toggle),
    .next_frame (next_frame),
    .frame_out  (frame_out),
    .frame_idx  (frame_idx),
    .playing    (playing)
  );

  typedef struct {
    logic        rst, en, edit, place;
    logic [34:0] cur;
    logic        play, nxt;
    logic [34:0] e_out;
    int          e_idx;
    logic        e_play;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic e, logic ed, logic pl, logic [34:0] c,
                              logic pt, logic nx, logic [34:0] eo, int ei, logic ep);
    vec_t v;
    v.rst = r; v.en = e; v.edit = ed; v.place = pl; v.cur = c;
    v.play = pt; v.nxt = nx; v.e_out = eo; v.e_idx = ei; v.e_play = ep;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one set of inputs between edges, then sample 1 ns after the edge.
  task automatic cycle(input logic r, input logic e, input logic ed, input logic pl,
                       input logic [34:0] c, input logic pt, input logic nx);
    @(negedge CLOCK_50);
    rst = r; en = e; edit = ed; place = pl; ens_cursor = c;
    play_toggle = pt; next_frame = nx;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Behavioural model: mode flag, elapsed ticks, index and picture array.
  bit          m_playing;
  int          m_idx, m_elapsed;
  logic [34:0] m_frames [NF];

  function automatic void model_step(logic r, logic e, logic ed, logic pl,
                                     logic [34:0] c, logic pt, logic nx);
    if (r) begin
      foreach (m_frames[i]) m_frames[i] = '0;
      m_playing = 0; m_idx = 0; m_elapsed = 0;
    end else if (e) begin
      if (pt) begin
        m_playing = !m_playing;
        m_elapsed = 0;
      end else if (!m_playing) begin
        if (ed && pl) m_frames[m_idx] = m_frames[m_idx] ^ c;
        if (nx) m_idx = (m_idx + 1) % NF;
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == FT) begin
          m_elapsed = 0;
          m_idx = (m_idx + 1) % NF;
        end
      end
    end
  endfunction

  initial begin
    logic [34:0] Z, B34;
    logic [63:0] rnd;
    logic [34:0] c;
    Z   = 35'h0;
    B34 = 35'h4_0000_0000;
    rst = 1'b1; en = 1'b0; edit = 1'b0; place = 1'b0; ens_cursor = '0;
    play_toggle = 1'b0; next_frame = 1'b0;

    //   rst en ed pl cur  pt nx  out          idx play
    // Reset and single-pixel toggle on/off.
    add(1, 0, 0, 0, Z,     0, 0,  Z,           0, 0);
    add(0, 1, 1, 1, 35'h1, 0, 0,  35'h1,       0, 0);
    add(0, 1, 1, 0, Z,     0, 0,  35'h1,       0, 0);
    add(0, 1, 1, 1, 35'h1, 0, 0,  Z,           0, 0);
    // Two frames written, manual stepping with wrap.
    add(0, 1, 1, 1, 35'h1, 0, 0,  35'h1,       0, 0);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           1, 0);
    add(0, 1, 1, 1, 35'h4, 0, 0,  35'h4,       1, 0);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           2, 0);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           3, 0);
    add(0, 1, 1, 0, Z,     0, 1,  35'h1,       0, 0);
    // Playback: advance every 4 cycles 0->1->2->3->0->1, then stop at idx 1.
    add(0, 1, 1, 0, Z,     1, 0,  35'h1,       0, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h1, 0, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h4,       1, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h4, 1, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, Z, 2, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           3, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, Z, 3, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h1,       0, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h1, 0, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h4,       1, 1);
    add(0, 1, 1, 0, Z,     1, 0,  35'h4,       1, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h4, 1, 0);
    // Place in PLAY dropped; place+play in STOP suppresses the write.
    add(0, 1, 1, 0, Z,     1, 0,  35'h4,       1, 1);
    add(0, 1, 1, 1, 35'h8, 0, 0,  35'h4,       1, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h4,       1, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h4,       1, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    add(0, 1, 1, 0, Z,     1, 0,  Z,           2, 0);
    add(0, 1, 1, 1, 35'h8, 1, 0,  Z,           2, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, Z, 2, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           3, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, Z, 3, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h1,       0, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h1, 0, 1);
    add(0, 1, 1, 0, Z,     0, 0,  35'h4,       1, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, 35'h4, 1, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    // en=0 for 10 cycles one tick into frame 2; pulses ignored meanwhile.
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    for (int k = 0; k < 10; k++) add(0, 0, 1, k[0], 35'h10, k[1], 1, Z, 2, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           2, 1);
    add(0, 1, 1, 0, Z,     0, 0,  Z,           3, 1);
    // play_toggle on the wrap cycle: stop wins, index stays at 3.
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, Z, 0, 0, Z, 3, 1);
    add(0, 1, 1, 0, Z,     1, 0,  Z,           3, 0);
    // Reset mid-PLAY (with en low) clears everything.
    add(0, 1, 1, 0, Z,     1, 0,  Z,           3, 1);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           3, 1);
    add(1, 0, 1, 1, 35'h1, 1, 1,  Z,           0, 0);
    add(0, 1, 0, 0, Z,     0, 1,  Z,           1, 0);
    add(0, 1, 0, 0, Z,     0, 1,  Z,           2, 0);
    add(0, 1, 0, 0, Z,     0, 1,  Z,           3, 0);
    add(0, 1, 0, 0, Z,     0, 1,  Z,           0, 0);
    // place+next hits the old index; play+next enters PLAY without a step.
    add(0, 1, 1, 1, B34,   0, 1,  Z,           1, 0);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           2, 0);
    add(0, 1, 1, 0, Z,     0, 1,  Z,           3, 0);
    add(0, 1, 1, 0, Z,     0, 1,  B34,         0, 0);
    add(0, 1, 1, 0, Z,     1, 1,  B34,         0, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].edit, tbl[i].place, tbl[i].cur,
            tbl[i].play, tbl[i].nxt);
      $display("vec %0d idx=%0d out=%h playing=%b", i, frame_idx, frame_out, playing);
      check($sformatf("vec%0d_out", i), 64'(frame_out), 64'(tbl[i].e_out));
      check($sformatf("vec%0d_idx", i), 64'(frame_idx), 64'(tbl[i].e_idx));
      check($sformatf("vec%0d_playing", i), 64'(playing), 64'(tbl[i].e_play));
    end

    // Randomized run against the behavioural model.
    model_step(1, 0, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, 0, '0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      logic r, e, ed, pl, pt, nx;
      rnd = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) c = rnd[34:0];
      else c = 35'h1 << $urandom_range(34, 0);
      r  = ($urandom_range(199, 0) == 0);
      e  = ($urandom_range(9, 0) != 0);
      ed = ($urandom_range(3, 0) != 0);
      pl = ($urandom_range(3, 0) == 0);
      pt = ($urandom_range(19, 0) == 0);
      nx = ($urandom_range(5, 0) == 0);
      model_step(r, e, ed, pl, c, pt, nx);
      cycle(r, e, ed, pl, c, pt, nx);
      $display("rnd %0d idx=%0d out=%h playing=%b", n, frame_idx, frame_out, playing);
      check($sformatf("rnd%0d_out", n), 64'(frame_out), 64'(m_frames[m_idx]));
      check($sformatf("rnd%0d_idx", n), 64'(frame_idx), 64'(m_idx));
      check($sformatf("rnd%0d_playing", n), 64'(playing), 64'(m_playing));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Multi-frame store and playback controller for the 5x7 LED picture path.
- Holds NFRAMES 35-bit pictures and arbitrates write access between the cursor editor (edit/place/ens_cursor from the key-driven selector) and a timed playback scheduler.
- Drives the 35-bit storage word consumed by the matrix scan/display logic, turning the single-picture editor into a frame-by-frame animation editor and player.

Parameters:
- NFRAMES, 4, number of stored frames; power of two, 2..16.
- IDX_W, 2, frame index width; equals log2(NFRAMES).
- FRAME_TICKS, 25000000, CLOCK_50 cycles per frame in playback (0.5 s); minimum 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low freezes all state.
- edit  in  1  editor in edit mode (level).
- place  in  1  one-cycle pulse: toggle the cursor pixel(s) in the current frame.
- ens_cursor  in  35  one-hot cursor mask, bit = row*7 + column.
- play_toggle  in  1  one-cycle pulse: start or stop playback.
- next_frame  in  1  one-cycle pulse: step to the next frame while stopped.
- frame_out  out  35  registered pixel word of the current frame, to the display.
- frame_idx  out  IDX_W  index of the current frame.
- playing  out  1  high while in the PLAY state.

Behaviour:
- Storage: NFRAMES x 35-bit register array.
- Reset (rst=1 at a clock edge):
  - all frames cleared to 0;
  - frame_idx=0, state=STOP, playing=0;
  - tick counter=0, frame_out=0.
- rst has priority over every other input, including en=0. A reset mid-playback returns to STOP, frame 0, blank.
- en=0: state, counter, frames, frame_idx and frame_out all hold. Input pulses are ignored, not queued.
- Arbitration rule: the editor owns the store only in STOP. Playback owns frame_idx only in PLAY.
- FSM states:
  - STOP:
    - play_toggle -> PLAY; counter cleared to 0.
    - next_frame -> frame_idx = (frame_idx+1) mod NFRAMES.
  - PLAY:
    - counter increments every enabled cycle.
    - When counter = FRAME_TICKS-1: counter -> 0 and frame_idx advances with wrap (NFRAMES-1 -> 0).
    - play_toggle -> STOP; frame_idx holds its current value; counter cleared.
    - next_frame is ignored.
- Write:
  - Condition: en & edit & place & state==STOP & !play_toggle.
  - Action: frames[frame_idx] <= frames[frame_idx] XOR ens_cursor.
  - XOR toggles set bits off and clear bits on; a multi-bit mask toggles each bit independently.
  - Writes in PLAY are dropped.
- Simultaneous events in STOP:
  - place + next_frame: the write targets the old index; frame_idx increments in the same edge.
  - place + play_toggle: play_toggle wins; the write is suppressed; enter PLAY.
  - play_toggle + next_frame: enter PLAY; no index step.
- Simultaneous events in PLAY:
  - play_toggle on the wrap cycle: STOP wins; frame_idx does not advance.
- frame_out:
  - Registered: frame_out <= frames[next frame_idx] with next-state contents.
  - Therefore it reflects a write or index change on the edge after the causing input, i.e. 1-cycle latency from pulse to visible output.
- playing = (state==PLAY), registered.
- Counter width: ceil(log2(FRAME_TICKS)); never exceeds FRAME_TICKS-1.

Test Plan:
- All tests use FRAME_TICKS=4, NFRAMES=4.
- Reset, then hold edit=1 and pulse place with ens_cursor=35'h1 -> next cycle frame_out=35'h1, frame_idx=0. Pulse place again with the same mask -> frame_out=0.
- Write 35'h1 into frame 0, pulse next_frame, write 35'h4 into frame 1, pulse next_frame three times -> frame_idx sequence 1,2,3,0. frame_out shows 35'h4 at idx 1, 0 at idx 2 and 3, 35'h1 at idx 0.
- From STOP at idx 0, pulse play_toggle -> playing=1. frame_idx advances every 4 cycles: 0 -> 1 -> 2 -> 3 -> 0. Pulse play_toggle again -> playing=0 and frame_idx frozen.
- In PLAY, pulse place with edit=1 and mask 35'h8 -> no frame contents change. Same cycle place+play_toggle in STOP -> PLAY entered and the target frame is unchanged.
- Hold en=0 for 10 cycles during PLAY -> frame_idx and counter frozen. Restore en=1 -> the advance occurs exactly the remaining cycles later.
- Assert rst mid-PLAY with nonzero frames -> next cycle playing=0, frame_idx=0, frame_out=0. Subsequent next_frame stepping shows every frame = 0.
